// File: rtl/dbg_run_ctrl_if.sv
// dbg_run_ctrl_if: host command handshake into the run/halt controller
interface dbg_run_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    modport master (output cmd_valid, cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, output cmd_ready);
endinterface

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: run/halt/single-step controller gating core commits, with cycle/instret counters
module dbg_run_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    dbg_run_ctrl_if.slave       cmd,
    input  logic                bp_en,
    input  logic [XLEN-1:0]     bp_addr,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     inst,
    input  logic                cnt_clr,
    output logic                commit_en,
    output logic                halted,
    output logic [1:0]          halt_cause,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instret_cnt
);
    localparam logic [1:0] HALTED = 2'd0, RUN = 2'd1, STEP = 2'd2;
    localparam logic [1:0] OP_RUN = 2'b01, OP_HALT = 2'b10, OP_STEP = 2'b11;
    localparam logic [XLEN-1:0] EBREAK = XLEN'(32'h00100073);
    logic [1:0] state, state_nx, cause_nx;
    logic       skip, hit, accept;
    always_comb begin
        hit           = !skip && ((bp_en && pc == bp_addr) || inst == EBREAK);
        // rst gates commit so nothing leaks through while reset is asserting
        commit_en     = rst && (state == STEP || (state == RUN && !hit));
        cmd.cmd_ready = state != STEP;
        accept        = cmd.cmd_valid && cmd.cmd_ready;
        state_nx      = state;
        cause_nx      = halt_cause;
        if (state == STEP) begin
            state_nx = HALTED;
            cause_nx = 2'b10;
        end else if (state == RUN && hit) begin
            state_nx = HALTED;
            cause_nx = 2'b11;
        end else if (state == RUN && accept && cmd.cmd_op == OP_HALT) begin
            state_nx = HALTED;
            cause_nx = 2'b01;
        end else if (state == HALTED && accept && cmd.cmd_op == OP_RUN) begin
            state_nx = RUN;
        end else if (state == HALTED && accept && cmd.cmd_op == OP_STEP) begin
            state_nx = STEP;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HALTED;
            halted      <= 1'b1;
            halt_cause  <= 2'b00;
            skip        <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            state       <= state_nx;
            halted      <= state_nx == HALTED;
            halt_cause  <= cause_nx;
            // first instruction after a resume is exempt from break checks
            skip        <= (state == HALTED && state_nx == RUN) ? 1'b1 : (state == RUN ? 1'b0 : skip);
            cycle_cnt   <= cnt_clr ? '0 : cycle_cnt + CNT_W'(state != HALTED);
            instret_cnt <= cnt_clr ? '0 : instret_cnt + CNT_W'(commit_en);
        end
    end
endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Run/halt/single-step controller for the single-cycle RV32 core. It gates every architectural state update: the PC register, the register-file write and the DMEM write. The core can therefore be started, stopped, single-stepped and stopped at a breakpoint or `ebreak`. It sits between the debug/host command source and the core datapath, and also keeps cycle and retired-instruction counters.

## Interface
Parameters:
- `XLEN`, 32, address/instruction width.
- `CNT_W`, 32, width of both counters.

Ports:
- `clk`, in, 1, core clock; all state updates on the rising edge.
- `rst`, in, 1, asynchronous, active-low reset.
- `cmd_valid`, in, 1, command present.
- `cmd_op`, in, 2, command code: 00 none, 01 run, 10 halt, 11 step.
- `cmd_ready`, out, 1, command accepted on the edge where `cmd_valid && cmd_ready`.
- `bp_en`, in, 1, hardware breakpoint enable.
- `bp_addr`, in, XLEN, breakpoint PC.
- `pc`, in, XLEN, current PC (PC register output).
- `inst`, in, XLEN, current instruction from IMEM.
- `cnt_clr`, in, 1, synchronous clear of both counters.
- `commit_en`, out, 1, combinational. When 1, this cycle's instruction commits; the PC, regfile and DMEM write enables are ANDed with it.
- `halted`, out, 1, 1 in HALTED state.
- `halt_cause`, out, 2, valid while halted: 00 reset, 01 halt command, 10 step done, 11 breakpoint/`ebreak`.
- `cycle_cnt`, out, CNT_W, cycles spent outside HALTED.
- `instret_cnt`, out, CNT_W, committed instructions.

## Operation
- FSM states: HALTED, RUN, STEP. Internal flag `skip` exempts the first instruction after leaving HALTED from break checks.
- Break hit: `!skip && ((bp_en && pc == bp_addr) || inst == 32'h00100073)`.
- `commit_en`:
  - HALTED: 0.
  - STEP: 1.
  - RUN: `!hit`.
- `cmd_ready` is 1 in HALTED and RUN, 0 in STEP.
- HALTED:
  - run → RUN, `skip` = 1.
  - step → STEP.
  - halt → ignored; state and cause unchanged.
- RUN:
  - If `hit`: → HALTED, cause 11. The instruction does not commit, and `pc` stays at the hit address.
  - Else, if a halt command is accepted: → HALTED, cause 01. That cycle's instruction still commits.
  - Run and step commands are accepted but have no effect.
  - `skip` clears after every RUN cycle.
  - `hit` has priority over a simultaneous halt command.
- STEP: exactly one cycle, exactly one commit, no break check. Then → HALTED, cause 10.
- Resuming with run at a breakpoint PC or an `ebreak` commits that instruction (via `skip`) and then continues normally.
- Counters:
  - `cycle_cnt` +1 on each edge where the state was RUN or STEP.
  - `instret_cnt` +1 on each edge where `commit_en` = 1.
  - `cnt_clr` forces both to 0 and overrides increment.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset (`rst` = 0, async):
  - state HALTED, `halted` = 1, `halt_cause` = 00, `commit_en` = 0.
  - `skip` = 0, `cycle_cnt` = 0, `instret_cnt` = 0.
- Reset deassertion takes effect at the next rising edge of `clk`.
- Reset mid-RUN drops `commit_en` immediately. No partial commit reaches the gated enables after `rst` falls.
- Command latency: state changes on the edge where the command is accepted. The first RUN cycle, with `commit_en` = 1, is the next cycle.
- Break latency: zero. `commit_en` falls combinationally in the same cycle `pc`/`inst` match, and `halted` rises one edge later.
- `halted` and `halt_cause` are registered outputs. `commit_en` is the only combinational output, with a path from `pc`, `inst`, `bp_*` and state.
- STEP lasts one cycle. The STEP → HALTED transition is unconditional, and no command is accepted in STEP.

## Test plan
- **Reset:** hold `rst` = 0 mid-run.
  - Expect `halted` = 1, `halt_cause` = 00, `commit_en` = 0 and counters 0 immediately.
  - Release `rst` with no command: expect the core to stay halted and `pc` to stay at 0.
- **Run then halt:** issue run, then halt 10 cycles later.
  - Expect 11 commits (including the halt cycle) and `instret_cnt` = 11, `cycle_cnt` = 11.
  - Expect `halt_cause` = 01.
- **Step:** from HALTED, issue step three times (gap ≥ 1 cycle each).
  - Expect `pc` to advance by exactly 3 instructions, `instret_cnt` = 3 and `cycle_cnt` = 3.
  - Expect `halt_cause` = 10 after each step, and `cmd_ready` = 0 during each STEP cycle.
- **Breakpoint:** `bp_en` = 1, `bp_addr` = 0x10, straight-line code from 0; issue run.
  - Expect a halt with `pc` = 0x10, `halt_cause` = 11 and `instret_cnt` = 4.
  - Issue run again: expect 0x10 to commit and execution to continue past 0x14.
- **`ebreak`:** place `ebreak` (32'h00100073) at 0x08; issue run.
  - Expect a halt at 0x08 with cause 11, and the regfile/DMEM write enables never asserted at 0x08.
  - Assert a halt command on the hit cycle too: expect cause 11.
- **Counters:** preload by running 2^CNT_W−1 cycles (`CNT_W` = 4 instance).
  - Expect wrap to 0 after 15 → 0.
  - Assert `cnt_clr` while running: expect both counters = 0 on the next edge.
